// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handshake and status.
// master = fetch unit, slave = the memory/decode/next-PC side.
interface pc_fetch_if;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  modport master (
    input  npc, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           fault, fault_code, retired
  );

  modport slave (
    output npc, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           fault, fault_code, retired
  );
endinterface

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch: request at pc, hold the word for decode,
// follow npc on accept, and latch a terminal fault on misaligned npc or memory timeout.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [7:0]  TIMEOUT  = 8'd16
) (
  input logic        clk,
  input logic        rst,
  pc_fetch_if.master bus
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_VALID = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

  logic [1:0]  state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instr_q,   instr_d;
  logic [7:0]  wait_q,    wait_d;
  logic [1:0]  code_q,    code_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    wait_d    = wait_q;
    code_d    = code_q;
    retired_d = retired_q;

    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          wait_d  = 8'd0;
          state_d = ST_VALID;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == TIMEOUT) begin
            state_d = ST_FAULT;
            code_d  = CODE_TIMEOUT;
          end
        end
      end
      ST_VALID: begin
        if (bus.instr_ready) begin
          retired_d = retired_q + 32'd1;
          if (bus.npc[1:0] == 2'b00) begin
            pc_d    = bus.npc;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FAULT;
            code_d  = CODE_MISALIGN;
          end
        end
      end
      default: ;  // fault (and any unused encoding) holds everything until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      wait_q    <= 8'd0;
      code_q    <= CODE_NONE;
      retired_q <= 32'd0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the pre-edge values of the others.
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      code_q    <= code_d;
      retired_q <= retired_d;
    end
  end

  // Request depends only on registered state and reset, never on decode-side inputs.
  assign bus.imem_req    = rst && (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == ST_VALID);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.fault_code  = code_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_pc_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(8'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the fetch unit is doing, as a phase of the fetch/hand-over cycle.
  typedef enum {M_FETCH, M_HOLD, M_DEAD} mphase_e;
  mphase_e     m_phase;
  bit          m_rst;
  int          m_waited;
  logic [31:0] m_pc, m_instr, m_retired;
  logic [1:0]  m_code;

  task automatic model_reset();
    m_phase   = M_FETCH;
    m_waited  = 0;
    m_pc      = RESET_PC;
    m_instr   = 32'd0;
    m_retired = 32'd0;
    m_code    = 2'b00;
  endtask

  task automatic model_update(input bit r, input bit a, input logic [31:0] d,
                              input bit rdy, input logic [31:0] n);
    m_rst = r;
    if (!r) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_FETCH: begin
        if (a) begin
          m_instr  = d;
          m_waited = 0;
          m_phase  = M_HOLD;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) begin
            m_phase = M_DEAD;
            m_code  = 2'b10;
          end
        end
      end
      M_HOLD: begin
        if (rdy) begin
          m_retired = m_retired + 1;
          if (n % 4 == 0) begin
            m_pc    = n;
            m_phase = M_FETCH;
          end else begin
            m_phase = M_DEAD;
            m_code  = 2'b01;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    bit exp_req;
    exp_req = m_rst && (m_phase == M_FETCH);
    check("imem_req",    bus.imem_req,    exp_req);
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    check("instr_valid", bus.instr_valid, m_phase == M_HOLD);
    check("instr",       bus.instr,       m_instr);
    check("pc",          bus.pc,          m_pc);
    check("pc_plus4",    bus.pc_plus4,    m_pc + 32'd4);
    check("fault",       bus.fault,       m_phase == M_DEAD);
    check("fault_code",  bus.fault_code,  m_code);
    check("retired",     bus.retired,     m_retired);
  endtask

  // One cycle: compare settled outputs, drive next inputs, advance the model, wait a cycle.
  task automatic step(input bit r, input bit a, input logic [31:0] d,
                      input bit rdy, input logic [31:0] n);
    compare_all();
    rst             = r;
    bus.imem_ack    = a;
    bus.imem_rdata  = d;
    bus.instr_ready = rdy;
    bus.npc         = n;
    model_update(r, a, d, rdy, n);
    @(negedge clk);
  endtask

  initial begin
    int ack_pct;
    int dead_cnt;
    bit r, a, rdy;
    logic [31:0] n;

    rst = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0; bus.npc = '0;
    m_rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset values.
    check("rst_req",     bus.imem_req, 1'b0);
    check("rst_pc",      bus.pc, 32'h0000_3000);
    check("rst_instr",   bus.instr, 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    check("rst_fault",   {bus.fault, bus.fault_code}, 3'b000);

    // Ack in the very first fetch cycle.
    step(1, 1, 32'h2008_0005, 0, 0);
    check("first_valid",  bus.instr_valid, 1'b1);
    check("first_instr",  bus.instr, 32'h2008_0005);
    check("first_pc",     bus.pc, 32'h0000_3000);
    check("first_pc4",    bus.pc_plus4, 32'h0000_3004);

    // Accept to 0x3010, ack delayed 3 cycles; ready/misaligned npc in fetch must be ignored.
    step(1, 0, 0, 1, 32'h0000_3010);
    check("acc_retired", bus.retired, 32'd1);
    check("acc_addr",    bus.imem_addr, 32'h0000_3010);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 32'h0000_0003);
      check("hold_addr", bus.imem_addr, 32'h0000_3010);
      check("hold_req",  bus.imem_req, 1'b1);
      check("hold_fault", bus.fault, 1'b0);
    end
    step(1, 1, 32'h00A0_0093, 0, 0);
    check("dly_valid", bus.instr_valid, 1'b1);
    check("dly_instr", bus.instr, 32'h00A0_0093);

    // Decode stalls 5 cycles; a stray ack outside fetch changes nothing.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'hDEAD_BEEF, 0, 32'h0000_4000);
      check("stall_instr",   bus.instr, 32'h00A0_0093);
      check("stall_pc",      bus.pc, 32'h0000_3010);
      check("stall_req",     bus.imem_req, 1'b0);
      check("stall_retired", bus.retired, 32'd1);
    end

    // Misaligned npc fault.
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h1111_2222, 0, 0);
    step(1, 0, 0, 1, 32'h0000_3012);
    check("mis_fault", {bus.fault, bus.fault_code}, 3'b101);
    check("mis_pc",    bus.pc, 32'h0000_3000);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h5555_AAAA, 1, 32'h0000_2000);
      check("mis_req",     bus.imem_req, 1'b0);
      check("mis_retired", bus.retired, 32'd1);
      check("mis_valid",   bus.instr_valid, 1'b0);
    end

    // Timeout: 16 fetch cycles without ack.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) check("to_pre_fault", bus.fault, 1'b0);
      step(1, 0, 0, 0, 0);
    end
    check("to_fault", {bus.fault, bus.fault_code}, 3'b110);
    check("to_req",   bus.imem_req, 1'b0);
    step(1, 1, 32'hCAFE_F00D, 1, 0);
    check("to_late_valid", bus.instr_valid, 1'b0);
    check("to_late_instr", bus.instr, 32'd0);

    // Reset pulsed mid-wait, asynchronously between edges.
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h0000_0013, 0, 0);
    step(1, 0, 0, 1, 32'h0000_5000);
    step(1, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("async_req", bus.imem_req, 1'b0);
    check("async_pc",  bus.pc, 32'h0000_3000);
    check("async_ret", bus.retired, 32'd0);
    m_rst = 1'b0;
    model_reset();
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    check("post_rst_addr", bus.imem_addr, 32'h0000_3000);
    check("post_rst_req",  bus.imem_req, 1'b1);

    // pc_plus4 wraps at the top of the address space.
    step(1, 1, 32'h0000_0067, 0, 0);
    step(1, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc_plus4, 32'd0);

    // Randomized traffic.
    ack_pct  = 70;
    dead_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 7))
          0:       ack_pct = 0;
          1, 2:    ack_pct = 20;
          default: ack_pct = 70;
        endcase
      end
      dead_cnt = (m_phase == M_DEAD) ? dead_cnt + 1 : 0;
      if (!m_rst)           r = 1'b1;
      else if (dead_cnt > 3) r = 1'b0;
      else                  r = ($urandom_range(0, 299) != 0);
      a   = ($urandom_range(0, 99) < ack_pct);
      rdy = $urandom_range(0, 1);
      n   = $urandom;
      if ($urandom_range(0, 29) != 0) n[1:0] = 2'b00;
      step(r, a, $urandom, rdy, n);
    end
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
